// File: rtl/saph_pixconv.sv
// Streaming pixel format converter: unpacks each source pixel to 8-bit ARGB,
// repacks it in the destination format and assembles 32-bit output words.
package saph_pixconv_pkg;
    typedef struct packed {
        logic [3:0] w;      // channel width in bits, 0 = channel absent
        logic [4:0] pos;    // LSB position of the channel within the pixel
    } chan_t;

    typedef struct packed {
        chan_t a;
        chan_t r;
        chan_t g;
        chan_t b;
    } pixfmt;
endpackage

module saph_pixconv
    import saph_pixconv_pkg::*;
#(
    parameter int unsigned cnt_width = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  pixfmt                src_fmt,
    input  pixfmt                dst_fmt,
    input  logic [2:0]           src_bpp_log,
    input  logic [2:0]           dst_bpp_log,
    input  logic [cnt_width-1:0] pix_count,
    output logic                 busy,
    output logic                 done,
    input  logic [31:0]          in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [31:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t               r_state, w_next;
    pixfmt                r_src_fmt, r_dst_fmt;
    logic [2:0]           r_sbl, r_dbl;
    logic [cnt_width-1:0] r_remaining, r_fetch_rem;
    logic [31:0]          r_src_word, r_acc, r_out_data;
    logic [4:0]           r_src_idx, r_acc_idx;
    logic                 r_src_valid, r_out_valid, r_out_last;

    function automatic logic [2:0] clamp_bl(input logic [2:0] b);
        return (b > 3'd5) ? 3'd5 : b;
    endfunction

    // Widen a w-bit field to 8 bits by repeating it from the MSB down.
    function automatic logic [7:0] expand(input logic [31:0] pix, input chan_t c);
        logic [3:0]  w;
        logic [7:0]  raw;
        logic [63:0] rep;
        w   = (c.w > 4'd8) ? 4'd8 : c.w;
        raw = 8'(pix >> c.pos) & 8'((9'd1 << w) - 9'd1);
        rep = '0;
        for (int unsigned i = 0; i < 8; i++)
            rep = rep | (64'(raw) << (i * w));
        return 8'(rep >> (32'(w) * 8 - 8));
    endfunction

    function automatic logic [31:0] unpack(input logic [31:0] pix, input pixfmt f);
        logic [7:0] a, r, g, b;
        a = (f.a.w == 4'd0) ? 8'hFF : expand(pix, f.a);
        r = (f.r.w == 4'd0) ? 8'h00 : expand(pix, f.r);
        g = (f.g.w == 4'd0) ? 8'h00 : expand(pix, f.g);
        b = (f.b.w == 4'd0) ? 8'h00 : expand(pix, f.b);
        return {a, r, g, b};
    endfunction

    function automatic logic [31:0] place(input logic [7:0] v, input chan_t c);
        logic [3:0] w;
        w = (c.w > 4'd8) ? 4'd8 : c.w;
        if (w == 4'd0)
            return '0;
        return 32'(v >> (4'd8 - w)) << c.pos;
    endfunction

    function automatic logic [31:0] pack(input logic [31:0] argb, input pixfmt f);
        return place(argb[31:24], f.a) | place(argb[23:16], f.r) |
               place(argb[15:8], f.g)  | place(argb[7:0], f.b);
    endfunction

    logic [5:0]  w_src_slots, w_dst_slots;
    logic [31:0] w_src_mask, w_dst_mask, w_pix, w_conv, w_merged;
    logic        w_final_pix, w_completes, w_out_free, w_fire;
    logic        w_src_release, w_in_ready, w_in_accept, w_out_accept;
    logic        w_busy, w_done;

    assign w_src_slots = 6'd32 >> r_sbl;
    assign w_dst_slots = 6'd32 >> r_dbl;
    assign w_src_mask  = 32'hFFFF_FFFF >> (6'd32 - (6'd1 << r_sbl));
    assign w_dst_mask  = 32'hFFFF_FFFF >> (6'd32 - (6'd1 << r_dbl));
    assign w_pix       = (r_src_word >> (r_src_idx << r_sbl)) & w_src_mask;
    assign w_conv      = pack(unpack(w_pix, r_src_fmt), r_dst_fmt) & w_dst_mask;
    assign w_merged    = r_acc | (w_conv << (r_acc_idx << r_dbl));

    // A pixel that completes a word goes straight to the output register,
    // so the accumulator never sits full and only such pixels need a free output.
    assign w_final_pix   = (r_remaining == cnt_width'(1));
    assign w_completes   = ({1'b0, r_acc_idx} == w_dst_slots - 6'd1) || w_final_pix;
    assign w_out_free    = !r_out_valid || out_ready;
    assign w_fire        = (r_state == S_RUN) && r_src_valid && (!w_completes || w_out_free);
    assign w_src_release = w_fire && (({1'b0, r_src_idx} == w_src_slots - 6'd1) || w_final_pix);
    assign w_in_ready    = (r_state == S_RUN) && (r_fetch_rem != '0) &&
                           (!r_src_valid || w_src_release);
    assign w_in_accept   = in_valid && w_in_ready;
    assign w_out_accept  = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = (pix_count == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                w_busy = 1'b1;
                if (w_fire && w_final_pix) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                w_busy = 1'b1;
                if (w_out_accept && r_out_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_src_fmt   <= '0;
            r_dst_fmt   <= '0;
            r_sbl       <= '0;
            r_dbl       <= '0;
            r_remaining <= '0;
            r_fetch_rem <= '0;
            r_src_word  <= '0;
            r_src_valid <= 1'b0;
            r_src_idx   <= '0;
            r_acc       <= '0;
            r_acc_idx   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_src_fmt   <= src_fmt;
                r_dst_fmt   <= dst_fmt;
                r_sbl       <= clamp_bl(src_bpp_log);
                r_dbl       <= clamp_bl(dst_bpp_log);
                r_remaining <= pix_count;
                r_fetch_rem <= pix_count;
                r_src_valid <= 1'b0;
                r_acc       <= '0;
                r_acc_idx   <= '0;
            end

            if (w_in_accept) begin
                r_src_word  <= in_data;
                r_src_valid <= 1'b1;
                r_src_idx   <= '0;
                r_fetch_rem <= (r_fetch_rem <= cnt_width'(w_src_slots)) ? '0
                             : r_fetch_rem - cnt_width'(w_src_slots);
            end else if (w_src_release) begin
                r_src_valid <= 1'b0;
            end else if (w_fire) begin
                r_src_idx <= r_src_idx + 5'd1;
            end

            if (w_fire) begin
                r_remaining <= r_remaining - cnt_width'(1);
                if (w_completes) begin
                    r_acc     <= '0;
                    r_acc_idx <= '0;
                end else begin
                    r_acc     <= w_merged;
                    r_acc_idx <= r_acc_idx + 5'd1;
                end
            end

            if (w_fire && w_completes) begin
                r_out_data  <= w_merged;
                r_out_valid <= 1'b1;
                r_out_last  <= w_final_pix;
            end else if (w_out_accept) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign busy      = w_busy;
    assign done      = w_done;
    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

endmodule
